// File: rtl/pwm_compare.sv
// PWM comparator fed by an up/down wrap counter. A duty request is held in a shadow register and goes live only at a period boundary.
// Latency: o_pwm and o_period_start are registered one cycle behind i_cnt. Backpressure: o_duty_ready stays low while the shadow register is full.
module pwm_compare #(
  parameter int NUM_MAX    = 16,
  parameter bit UP_DOWN    = 1'b1,
  parameter int DATA_WIDTH = $clog2(NUM_MAX + 1),
  parameter int DUTY_WIDTH = $clog2(NUM_MAX + 2),
  parameter bit POLARITY   = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ena,
  input  logic [DATA_WIDTH-1:0] i_cnt,
  input  logic [DUTY_WIDTH-1:0] i_duty,
  input  logic                  i_duty_valid,
  output logic                  o_duty_ready,
  output logic                  o_pwm,
  output logic                  o_period_start,
  output logic [DUTY_WIDTH-1:0] o_duty_active
);

  // One spare bit so NUM_MAX+1 and the clamp compare never overflow.
  localparam int CW = ((DATA_WIDTH > DUTY_WIDTH) ? DATA_WIDTH : DUTY_WIDTH) + 1;
  localparam logic [CW-1:0] MAX_C  = CW'(NUM_MAX);
  localparam logic [CW-1:0] FULL_C = CW'(NUM_MAX + 1);
  localparam logic [DATA_WIDTH-1:0] LAST_CNT = UP_DOWN ? DATA_WIDTH'(NUM_MAX) : '0;

  if (NUM_MAX < 1) begin : g_bad_num_max
    $error("pwm_compare: NUM_MAX must be at least 1");
  end

  logic [DUTY_WIDTH-1:0] pending;
  logic                  pending_full;
  logic [DUTY_WIDTH-1:0] active;
  logic [CW-1:0]         pos;
  logic [CW-1:0]         pending_ext;
  logic [CW-1:0]         clamped;
  logic                  boundary;
  logic                  transfer;

  always_comb begin
    pos         = UP_DOWN ? CW'(i_cnt) : (MAX_C - CW'(i_cnt));
    boundary    = i_ena && (i_cnt == LAST_CNT);
    transfer    = i_duty_valid && !pending_full;
    pending_ext = CW'(pending);
    clamped     = (pending_ext > FULL_C) ? FULL_C : pending_ext;
  end

  // Transfer and apply are exclusive: a full shadow register blocks new transfers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pending        <= '0;
      pending_full   <= 1'b0;
      active         <= '0;
      o_pwm          <= !POLARITY;
      o_period_start <= 1'b0;
    end else begin
      if (transfer) begin
        pending      <= i_duty;
        pending_full <= 1'b1;
      end
      if (boundary && pending_full) begin
        active       <= DUTY_WIDTH'(clamped);
        pending_full <= 1'b0;
      end
      o_pwm          <= (pos < CW'(active)) ? POLARITY : !POLARITY;
      o_period_start <= boundary;
    end
  end

  assign o_duty_ready  = !pending_full;
  assign o_duty_active = active;

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare: one up-counting and one down-counting instance with NUM_MAX=4, driven from tables of hand-computed vectors.
module tb_pwm_compare;
  localparam int NM = 4;
  localparam int DW = $clog2(NM + 1);
  localparam int UW = $clog2(NM + 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [DW-1:0] cnt_up = '0, cnt_dn = DW'(NM);
  logic [UW-1:0] duty_up = '0, duty_dn = '0;
  logic          vld_up = 1'b0, vld_dn = 1'b0;
  logic          rdy_up, pwm_up, ps_up, rdy_dn, pwm_dn, ps_dn;
  logic [UW-1:0] act_up, act_dn;

  always #5 clk = ~clk;

  pwm_compare #(.NUM_MAX(NM), .UP_DOWN(1'b1), .POLARITY(1'b1)) dut_up (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_cnt(cnt_up),
    .i_duty(duty_up), .i_duty_valid(vld_up), .o_duty_ready(rdy_up),
    .o_pwm(pwm_up), .o_period_start(ps_up), .o_duty_active(act_up)
  );

  pwm_compare #(.NUM_MAX(NM), .UP_DOWN(1'b0), .POLARITY(1'b1)) dut_dn (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_cnt(cnt_dn),
    .i_duty(duty_dn), .i_duty_valid(vld_dn), .o_duty_ready(rdy_dn),
    .o_pwm(pwm_dn), .o_period_start(ps_dn), .o_duty_active(act_dn)
  );

  typedef struct {
    logic          ena;
    logic [DW-1:0] cnt;
    logic          vld;
    logic [UW-1:0] duty;
    logic          pwm;
    logic          ps;
    logic          rdy;
    logic [UW-1:0] act;
  } vec_t;

  vec_t up_q[$];
  vec_t dn_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input int e, c, v, d, p, s, r, a);
    vec_t t;
    t.ena  = e[0];
    t.cnt  = DW'(c);
    t.vld  = v[0];
    t.duty = UW'(d);
    t.pwm  = p[0];
    t.ps   = s[0];
    t.rdy  = r[0];
    t.act  = UW'(a);
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, got, want);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic apply(input bit dn, input vec_t t, input int idx);
    @(negedge clk);
    ena = t.ena;
    if (dn) begin
      cnt_dn = t.cnt; vld_dn = t.vld; duty_dn = t.duty;
    end else begin
      cnt_up = t.cnt; vld_up = t.vld; duty_up = t.duty;
    end
    @(posedge clk);
    #1;
    if (dn) begin
      check("dn_pwm", idx, 8'(pwm_dn), 8'(t.pwm));
      check("dn_period_start", idx, 8'(ps_dn), 8'(t.ps));
      check("dn_ready", idx, 8'(rdy_dn), 8'(t.rdy));
      check("dn_active", idx, 8'(act_dn), 8'(t.act));
    end else begin
      check("up_pwm", idx, 8'(pwm_up), 8'(t.pwm));
      check("up_period_start", idx, 8'(ps_up), 8'(t.ps));
      check("up_ready", idx, 8'(rdy_up), 8'(t.rdy));
      check("up_active", idx, 8'(act_up), 8'(t.act));
    end
  endtask

  task automatic do_reset(input int tag);
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b1; vld_up = 1'b0; vld_dn = 1'b0;
    @(posedge clk);
    #1;
    check("rst_up_pwm", tag, 8'(pwm_up), 8'd0);
    check("rst_up_period_start", tag, 8'(ps_up), 8'd0);
    check("rst_up_ready", tag, 8'(rdy_up), 8'd1);
    check("rst_up_active", tag, 8'(act_up), 8'd0);
    check("rst_dn_pwm", tag, 8'(pwm_dn), 8'd0);
    check("rst_dn_ready", tag, 8'(rdy_dn), 8'd1);
    check("rst_dn_active", tag, 8'(act_dn), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //                 ena cnt vld duty | pwm ps rdy act
    // Duty 2 written at reset release: period 1 at duty 0, then 1,1,0,0,0.
    up_q.push_back(mk(1, 0, 1, 2, 0, 0, 0, 0));
    up_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    up_q.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0));
    up_q.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0));
    up_q.push_back(mk(1, 4, 0, 0, 0, 1, 1, 2));
    up_q.push_back(mk(1, 0, 0, 0, 1, 0, 1, 2));
    up_q.push_back(mk(1, 1, 0, 0, 1, 0, 1, 2));
    up_q.push_back(mk(1, 2, 0, 0, 0, 0, 1, 2));
    up_q.push_back(mk(1, 3, 0, 0, 0, 0, 1, 2));
    up_q.push_back(mk(1, 4, 0, 0, 0, 1, 1, 2));
    // Duty 3 written mid-period: old duty finishes the period.
    up_q.push_back(mk(1, 0, 0, 0, 1, 0, 1, 2));
    up_q.push_back(mk(1, 1, 1, 3, 1, 0, 0, 2));
    up_q.push_back(mk(1, 2, 0, 0, 0, 0, 0, 2));
    up_q.push_back(mk(1, 3, 0, 0, 0, 0, 0, 2));
    up_q.push_back(mk(1, 4, 0, 0, 0, 1, 1, 3));
    up_q.push_back(mk(1, 0, 0, 0, 1, 0, 1, 3));
    up_q.push_back(mk(1, 1, 0, 0, 1, 0, 1, 3));
    up_q.push_back(mk(1, 2, 0, 0, 1, 0, 1, 3));
    up_q.push_back(mk(1, 3, 0, 0, 0, 0, 1, 3));
    up_q.push_back(mk(1, 4, 0, 0, 0, 1, 1, 3));
    // Extremes: duty 0, then 5 (100 %), then 7 which clamps to 5.
    up_q.push_back(mk(1, 0, 1, 0, 1, 0, 0, 3));
    up_q.push_back(mk(1, 1, 0, 0, 1, 0, 0, 3));
    up_q.push_back(mk(1, 2, 0, 0, 1, 0, 0, 3));
    up_q.push_back(mk(1, 3, 0, 0, 0, 0, 0, 3));
    up_q.push_back(mk(1, 4, 0, 0, 0, 1, 1, 0));
    up_q.push_back(mk(1, 0, 1, 5, 0, 0, 0, 0));
    up_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    up_q.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0));
    up_q.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0));
    up_q.push_back(mk(1, 4, 0, 0, 0, 1, 1, 5));
    up_q.push_back(mk(1, 0, 1, 7, 1, 0, 0, 5));
    up_q.push_back(mk(1, 1, 0, 0, 1, 0, 0, 5));
    up_q.push_back(mk(1, 2, 0, 0, 1, 0, 0, 5));
    up_q.push_back(mk(1, 3, 0, 0, 1, 0, 0, 5));
    up_q.push_back(mk(1, 4, 0, 0, 1, 1, 1, 5));
    up_q.push_back(mk(1, 0, 0, 0, 1, 0, 1, 5));
    up_q.push_back(mk(1, 1, 0, 0, 1, 0, 1, 5));
    // Back-pressure: valid held with 1, then 4; neither is lost.
    up_q.push_back(mk(1, 2, 1, 1, 1, 0, 0, 5));
    up_q.push_back(mk(1, 3, 1, 4, 1, 0, 0, 5));
    up_q.push_back(mk(1, 4, 1, 4, 1, 1, 1, 1));
    up_q.push_back(mk(1, 0, 1, 4, 1, 0, 0, 1));
    up_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));
    up_q.push_back(mk(1, 2, 0, 0, 0, 0, 0, 1));
    up_q.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1));
    up_q.push_back(mk(1, 4, 0, 0, 0, 1, 1, 4));
    up_q.push_back(mk(1, 0, 0, 0, 1, 0, 1, 4));
    up_q.push_back(mk(1, 1, 0, 0, 1, 0, 1, 4));
    up_q.push_back(mk(1, 2, 0, 0, 1, 0, 1, 4));
    up_q.push_back(mk(1, 3, 0, 0, 1, 0, 1, 4));
    up_q.push_back(mk(1, 4, 0, 0, 0, 1, 1, 4));
    // Enable gap of 3 cycles at the last count: no boundary, duty held pending.
    up_q.push_back(mk(1, 0, 0, 0, 1, 0, 1, 4));
    up_q.push_back(mk(1, 1, 1, 2, 1, 0, 0, 4));
    up_q.push_back(mk(1, 2, 0, 0, 1, 0, 0, 4));
    up_q.push_back(mk(1, 3, 0, 0, 1, 0, 0, 4));
    up_q.push_back(mk(0, 4, 0, 0, 0, 0, 0, 4));
    up_q.push_back(mk(0, 4, 0, 0, 0, 0, 0, 4));
    up_q.push_back(mk(0, 4, 0, 0, 0, 0, 0, 4));
    up_q.push_back(mk(1, 4, 0, 0, 0, 1, 1, 2));
    up_q.push_back(mk(1, 0, 0, 0, 1, 0, 1, 2));
    // Pending filled just before a mid-period reset.
    up_q.push_back(mk(1, 1, 1, 3, 1, 0, 0, 2));
    up_q.push_back(mk(1, 2, 0, 0, 0, 0, 0, 2));

    // Down counter: 4,3,2,1,0 with duty 2 gives 1,1,0,0,0 from period 2.
    dn_q.push_back(mk(1, 4, 1, 2, 0, 0, 0, 0));
    dn_q.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0));
    dn_q.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0));
    dn_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    dn_q.push_back(mk(1, 0, 0, 0, 0, 1, 1, 2));
    dn_q.push_back(mk(1, 4, 0, 0, 1, 0, 1, 2));
    dn_q.push_back(mk(1, 3, 0, 0, 1, 0, 1, 2));
    dn_q.push_back(mk(1, 2, 0, 0, 0, 0, 1, 2));
    dn_q.push_back(mk(1, 1, 0, 0, 0, 0, 1, 2));
    dn_q.push_back(mk(1, 0, 0, 0, 0, 1, 1, 2));
    dn_q.push_back(mk(1, 4, 0, 0, 1, 0, 1, 2));

    do_reset(0);
    for (int i = 0; i < up_q.size(); i++) apply(1'b0, up_q[i], i);

    // Reset with pending full in mid-period: nothing survives.
    cnt_up = DW'(3);
    do_reset(1);
    for (int i = 0; i <= NM + 1; i++) begin
      apply(1'b0, mk(1, i % (NM + 1), 0, 0, 0, (i == NM) ? 1 : 0, 1, 0), 100 + i);
    end

    do_reset(2);
    for (int i = 0; i < dn_q.size(); i++) apply(1'b1, dn_q[i], i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
